uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//  Serial UART transmitter directly downstream of the UART send controller.
//  - Accepts one byte per ld_tx_data pulse into a holding register.
//  - While tx_enable is high, moves that byte into a shift register and sends it on tx_out.
//  - Frame: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
//  - The holding register plus the shift register let the controller load the next byte while the current one is being sent.
// PARAMETERS
//  CLKS_PER_BIT  16  clock cycles per serial bit; legal range 2..65535
//  PARITY_EN     0   1 = insert a parity bit after the data bits
//  PARITY_ODD    0   0 = even parity, 1 = odd parity; ignored when PARITY_EN=0
//  STOP_BITS     1   number of stop bits; 1 or 2
// PORTS
//  clock        in   1  system clock; all logic on the rising edge
//  reset        in   1  synchronous, active-high reset
//  ld_tx_data   in   1  load strobe; tx_data is captured when tx_empty=1
//  tx_data      in   8  byte to send
//  tx_enable    in   1  permits a new frame to start; does not abort a frame already started
//  tx_out       out  1  serial line; idle level is 1
//  tx_empty     out  1  1 = holding register free
//  tx_busy      out  1  1 = a frame is in progress (state != IDLE)
//  tx_done      out  1  one-cycle pulse on the last cycle of the final stop bit
//  tx_overrun   out  1  sticky; set when ld_tx_data arrives while tx_empty=0
// BEHAVIOUR
//  Reset (synchronous, takes effect at the next edge):
//  - tx_out=1, tx_empty=1, tx_busy=0, tx_done=0, tx_overrun=0.
//  - State=IDLE, baud counter=0, bit index=0, holding and shift registers=0.
//  - Reset mid-frame abandons the frame: tx_out=1 at the next edge, no tx_done.
//  Load path:
//  - ld_tx_data=1 with tx_empty=1 at edge N: holding<=tx_data, tx_empty=0 from N+1.
//  - ld_tx_data=1 with tx_empty=0: data discarded, tx_overrun<=1.
//  - tx_empty is sampled before any same-edge transfer. A load in the same cycle as a transfer therefore counts as an overrun.
//  FSM states: IDLE, START, DATA, PARITY, STOP. tx_out is registered and follows the state.
//  - IDLE: if tx_enable && !tx_empty:
//    - shift<=holding, tx_empty<=1 -> START.
//    - Byte loaded at N with tx_enable high: tx_out falls at N+2.
//  - START: tx_out=0 for CLKS_PER_BIT cycles -> DATA.
//  - DATA: tx_out=shift[idx], idx 0..7, each bit held for CLKS_PER_BIT cycles.
//    - After idx 7 -> PARITY if PARITY_EN, else STOP.
//    - idx wraps back to 0 for the next frame.
//  - PARITY: tx_out=^shift (even) or ~^shift (odd), for CLKS_PER_BIT cycles -> STOP.
//  - STOP: tx_out=1 for STOP_BITS*CLKS_PER_BIT cycles; tx_done=1 on the last cycle.
//    - Then, if tx_enable && !tx_empty: transfer and go to START (no idle gap).
//    - Otherwise go to IDLE.
//  Baud counter:
//  - Width is clog2(STOP_BITS*CLKS_PER_BIT).
//  - Cleared on every state change; terminal count = bit length - 1.
//  Frame length:
//  - (1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
//  - Default parameters: 160 cycles.
//  tx_enable deasserted mid-frame:
//  - The frame completes unchanged.
//  - Only the next frame start is blocked.
//  tx_overrun clears only on reset.
// TESTING
//  T1 CLKS_PER_BIT=4, load 0x55, tx_enable=1
//     -> tx_out: 0x4, then 1,0,1,0,1,0,1,0 (4 cycles each), then 1x4.
//     -> tx_done pulses once, 40 cycles after start; tx_busy=0 afterwards.
//  T2 Load 0xA5, wait for tx_empty=1, load 0x3C, tx_enable held high
//     -> the stop bit of 0xA5 is followed directly by the start bit of 0x3C; no idle cycle.
//  T3 Load 0x11, then load 0x22 while tx_empty=0
//     -> tx_overrun=1; only 0x11 is transmitted; tx_overrun stays 1 until reset.
//  T4 Load 0x81, tx_enable high for 9 cycles then low, CLKS_PER_BIT=16
//     -> the full 160-cycle frame is sent; no second frame.
//  T5 PARITY_EN=1, data 0x07
//     -> even parity: parity bit=1; PARITY_ODD=1: parity bit=0.
//     -> frame is 176 cycles at CLKS_PER_BIT=16.
//  T6 reset=1 during data bit 3
//     -> next edge: tx_out=1, tx_empty=1, tx_busy=0, tx_done never pulses.

Source files
------------

// File: rtl/uart_tx_serializer.sv
`timescale 1ns/1ps
// uart_tx_serializer
//   Serial UART transmitter fed by the UART send controller. A holding
//   register takes one byte per load strobe. The FSM moves the byte into a
//   shift register and sends it as one frame: a start bit, 8 data bits LSB
//   first, an optional parity bit, then 1 or 2 stop bits. The controller can
//   load the next byte while the current frame is still on the line.
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   ld_tx_data  in   load strobe for tx_data
//   tx_data     in   [7:0] byte to send
//   tx_enable   in   permits a new frame to start (never aborts a frame)
//   tx_out      out  serial line, idle high, registered
//   tx_empty    out  holding register free
//   tx_busy     out  a frame is on the line
//   tx_done     out  one-cycle pulse on the last cycle of the final stop bit
//   tx_overrun  out  sticky; a load arrived while the holding register was full
//   dbg_state   out  [2:0] current FSM state, for debug and checkers
//
// Handshake: the ld_tx_data/tx_empty pair is a valid/ready pair. A byte is
// accepted on any rising edge where ld_tx_data=1 and tx_empty=1. A strobe
// while tx_empty=0 is dropped and raises tx_overrun. tx_empty is sampled
// before any transfer on the same edge, so a load on the transfer edge is an
// overrun.

module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ld_tx_data,
   input  logic [7:0] tx_data,
   input  logic       tx_enable,
   output logic       tx_out,
   output logic       tx_empty,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_overrun,
   output logic [2:0] dbg_state
);

   localparam int STOP_LEN = STOP_BITS * CLKS_PER_BIT;
   localparam int CNT_W    = $clog2(STOP_LEN);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       holding;
   logic [7:0]       shift;

   logic bit_last;
   logic stop_last;
   logic take_next;
   logic parity_bit;

   assign bit_last   = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign stop_last  = (baud_cnt == CNT_W'(STOP_LEN - 1));
   assign take_next  = tx_enable && !tx_empty;
   assign parity_bit = (PARITY_ODD != 0) ? ~(^shift) : (^shift);
   assign dbg_state  = state;

   // tx_out, tx_busy and tx_done are registered from the current state, so
   // the line lags the state by one cycle. That lag gives the two-edge
   // load-to-start-bit latency, and it puts tx_done on the last line cycle
   // of the final stop bit.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         holding    <= '0;
         shift      <= '0;
         tx_out     <= 1'b1;
         tx_empty   <= 1'b1;
         tx_busy    <= 1'b0;
         tx_done    <= 1'b0;
         tx_overrun <= 1'b0;
      end else begin
         // A load and a transfer can never both write tx_empty on one edge.
         // A load needs tx_empty=1 and a transfer needs tx_empty=0.
         if (ld_tx_data) begin
            if (tx_empty) begin
               holding  <= tx_data;
               tx_empty <= 1'b0;
            end else begin
               tx_overrun <= 1'b1;
            end
         end

         tx_busy <= (state != IDLE);
         tx_done <= (state == STOP) && stop_last;

         case (state)
            IDLE: begin
               tx_out <= 1'b1;
               if (take_next) begin
                  shift    <= holding;
                  tx_empty <= 1'b1;
                  baud_cnt <= '0;
                  state    <= START;
               end
            end
            START: begin
               tx_out <= 1'b0;
               if (bit_last) begin
                  baud_cnt <= '0;
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               tx_out <= shift[bit_idx];
               if (bit_last) begin
                  baud_cnt <= '0;
                  // bit_idx wraps 7 -> 0, so it is ready for the next frame.
                  bit_idx  <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state <= (PARITY_EN != 0) ? PARITY : STOP;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            PARITY: begin
               tx_out <= parity_bit;
               if (bit_last) begin
                  baud_cnt <= '0;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               tx_out <= 1'b1;
               if (stop_last) begin
                  baud_cnt <= '0;
                  // When a byte is waiting, the next start bit follows
                  // directly, with no idle cycle.
                  if (take_next) begin
                     shift    <= holding;
                     tx_empty <= 1'b1;
                     state    <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               tx_out   <= 1'b1;
               baud_cnt <= '0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
`timescale 1ns/1ps
module tb_uart_tx_serializer;

   logic clock;
   int   checks = 0;
   int   errors = 0;
   int   n_fin  = 0;

   // clock / watchdog
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input int inst,
                        input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %0h, required %0h", name, inst, act, exp);
      end
   endtask

   // Three configurations: fast no-parity, default-rate even parity (176-cycle
   // frame), odd parity with two stop bits.
   for (genvar g = 0; g < 3; g++) begin : inst
      localparam int CPB   = (g == 0) ? 4 : (g == 1) ? 16 : 5;
      localparam int PE    = (g == 0) ? 0 : 1;
      localparam int PO    = (g == 2) ? 1 : 0;
      localparam int SB    = (g == 2) ? 2 : 1;
      localparam int NBITS = 9 + PE + SB;
      localparam int FRAME = NBITS * CPB;
      localparam int LIMIT = 4 * FRAME + 50;

      logic       rst, ld, en;
      logic [7:0] data;
      logic       tx_out, tx_empty, tx_busy, tx_done, tx_overrun;
      logic [2:0] dbg_state;
      logic [7:0] exp_q[$];

      uart_tx_serializer #(
         .CLKS_PER_BIT(CPB),
         .PARITY_EN   (PE),
         .PARITY_ODD  (PO),
         .STOP_BITS   (SB)
      ) dut (
         .clock     (clock),
         .reset     (rst),
         .ld_tx_data(ld),
         .tx_data   (data),
         .tx_enable (en),
         .tx_out    (tx_out),
         .tx_empty  (tx_empty),
         .tx_busy   (tx_busy),
         .tx_done   (tx_done),
         .tx_overrun(tx_overrun),
         .dbg_state (dbg_state)
      );

      // driver tasks
      task automatic cyc(input int n);
         repeat (n) @(negedge clock);
      endtask

      task automatic load(input logic [7:0] b, input bit expect_send);
         data = b;
         ld   = 1'b1;
         @(negedge clock);
         ld   = 1'b0;
         if (expect_send) exp_q.push_back(b);
      endtask

      task automatic wait_empty();
         int n;
         n = 0;
         while (tx_empty !== 1'b1 && n < LIMIT) begin
            @(negedge clock);
            n++;
         end
         check("wait_empty", g, 32'(tx_empty), 32'd1);
      endtask

      task automatic wait_done();
         int n;
         n = 0;
         while (tx_done !== 1'b1 && n < LIMIT) begin
            @(negedge clock);
            n++;
         end
         check("wait_done", g, 32'(tx_done), 32'd1);
      endtask

      task automatic drain();
         int n;
         n = 0;
         while (exp_q.size() != 0 && n < 3 * LIMIT) begin
            @(negedge clock);
            n++;
         end
         check("drain", g, 32'(exp_q.size()), 32'd0);
         cyc(2);
      endtask

      task automatic idle_for(input int n, input string name);
         logic saw_low, saw_done;
         saw_low  = 1'b0;
         saw_done = 1'b0;
         repeat (n) begin
            @(negedge clock);
            if (tx_out !== 1'b1) saw_low = 1'b1;
            if (tx_done !== 1'b0) saw_done = 1'b1;
         end
         check(name, g, {30'd0, saw_low, saw_done}, 32'd0);
      endtask

      // stimulus
      initial begin : stim
         int gap;
         rst = 1'b1; ld = 1'b0; en = 1'b0; data = 8'h00;
         cyc(3);
         check("rst_tx_out", g, 32'(tx_out), 32'd1);
         check("rst_empty", g, 32'(tx_empty), 32'd1);
         check("rst_busy", g, 32'(tx_busy), 32'd0);
         check("rst_done", g, 32'(tx_done), 32'd0);
         check("rst_overrun", g, 32'(tx_overrun), 32'd0);
         rst = 1'b0;
         cyc(2);

         // Start latency: a load at edge N makes tx_out fall at edge N+2.
         en = 1'b1;
         load((g == 0) ? 8'h55 : 8'h07, 1'b1);
         check("empty_after_load", g, 32'(tx_empty), 32'd0);
         check("line_after_load", g, 32'(tx_out), 32'd1);
         @(negedge clock);
         check("empty_after_transfer", g, 32'(tx_empty), 32'd1);
         check("line_n1", g, 32'(tx_out), 32'd1);
         @(negedge clock);
         check("start_edge", g, 32'(tx_out), 32'd0);
         check("busy_in_frame", g, 32'(tx_busy), 32'd1);
         wait_done();
         @(negedge clock);
         check("busy_after_frame", g, 32'(tx_busy), 32'd0);
         check("done_one_cycle", g, 32'(tx_done), 32'd0);

         // random traffic with tx_enable toggling between loads
         for (int i = 0; i < 10; i++) begin
            gap = $urandom_range(0, FRAME);
            repeat (gap) begin
               en = ($urandom_range(0, 3) != 0);
               @(negedge clock);
            end
            en = 1'b1;
            wait_empty();
            load(8'($urandom_range(0, 255)), 1'b1);
         end
         en = 1'b1;
         drain();

         // back-to-back frames: no idle cycle between stop and start
         load(8'hA5, 1'b1);
         wait_empty();
         load(8'h3C, 1'b1);
         wait_done();
         @(negedge clock);
         check("b2b_no_gap", g, 32'(tx_out), 32'd0);
         check("b2b_busy", g, 32'(tx_busy), 32'd1);
         drain();

         // enable dropped mid-frame: the frame finishes, the next one waits
         load(8'h81, 1'b1);
         cyc(8);
         en = 1'b0;
         wait_empty();
         load(8'h42, 1'b0);
         wait_done();
         idle_for(3 * CPB, "enable_blocks_start");
         check("holding_kept", g, 32'(tx_empty), 32'd0);
         exp_q.push_back(8'h42);
         en = 1'b1;
         drain();

         // overrun: the second load lands on the transfer edge and is dropped
         load(8'h11, 1'b1);
         check("full_before_ovr", g, 32'(tx_empty), 32'd0);
         load(8'h22, 1'b0);
         check("overrun_set", g, 32'(tx_overrun), 32'd1);
         drain();
         cyc(5);
         check("overrun_sticky", g, 32'(tx_overrun), 32'd1);

         // reset during data bit 3 abandons the frame
         load(8'h96, 1'b0);
         cyc(3 + 4 * CPB);
         rst = 1'b1;
         @(negedge clock);
         check("midrst_tx_out", g, 32'(tx_out), 32'd1);
         check("midrst_empty", g, 32'(tx_empty), 32'd1);
         check("midrst_busy", g, 32'(tx_busy), 32'd0);
         check("midrst_done", g, 32'(tx_done), 32'd0);
         check("midrst_overrun", g, 32'(tx_overrun), 32'd0);
         @(negedge clock);
         rst = 1'b0;
         idle_for(2 * FRAME, "no_frame_after_reset");
         check("pending_frames", g, 32'(exp_q.size()), 32'd0);
         n_fin++;
      end

      // monitor: decodes each frame off the line and scores it against exp_q
      initial begin : monitor
         logic       bits [0:11];
         logic [7:0] got, want;
         logic       exp9;
         bit         aborted, shape_ok, done_ok, busy_ok, stop_ok;
         forever begin
            @(negedge clock);
            if (rst !== 1'b0 || tx_out !== 1'b0) continue;
            aborted  = 1'b0;
            shape_ok = 1'b1;
            done_ok  = 1'b1;
            busy_ok  = 1'b1;
            for (int b = 0; b < NBITS; b++) begin
               for (int c = 0; c < CPB; c++) begin
                  if (b != 0 || c != 0) @(negedge clock);
                  if (rst !== 1'b0) aborted = 1'b1;
                  if (aborted) break;
                  if (c == 0) bits[b] = tx_out;
                  else if (tx_out !== bits[b]) shape_ok = 1'b0;
                  if (tx_done !== ((b == NBITS - 1) && (c == CPB - 1))) done_ok = 1'b0;
                  if (tx_busy !== 1'b1) busy_ok = 1'b0;
               end
               if (aborted) break;
            end
            if (aborted) continue;
            for (int k = 0; k < 8; k++) got[k] = bits[1 + k];
            stop_ok = 1'b1;
            for (int k = 9 + PE; k < NBITS; k++) if (bits[k] !== 1'b1) stop_ok = 1'b0;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame[%0d]: got byte %02h, required no frame", g, got);
            end else begin
               want = exp_q.pop_front();
               // slot after the data bits: parity when enabled, else first stop bit
               exp9 = 1'b1;
               if (PE != 0) begin
                  exp9 = 1'($countones(want) & 1);
                  if (PO != 0) exp9 = ~exp9;
               end
               check("frame_data", g, 32'(got), 32'(want));
               check("frame_shape", g, 32'(shape_ok), 32'd1);
               check("frame_done", g, 32'(done_ok), 32'd1);
               check("frame_busy", g, 32'(busy_ok), 32'd1);
               check("frame_stop", g, 32'(stop_ok), 32'd1);
               check("bit_after_data", g, 32'(bits[9]), 32'(exp9));
            end
         end
      end
   end

   // final report
   initial begin
      wait (n_fin == 3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
